// File: rtl/ram_responder.sv
// Burst memory responder for one cache port: serves AW/W write bursts and AR/R read
// bursts from an internal word array through a wrapping word pointer.
module ram_responder #(
    parameter int AWIDTH    = 32,
    parameter int LWIDTH    = 8,
    parameter int DWIDTH    = 32,
    parameter int DEPTH     = 4096,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] ram_awaddr,
    input  logic [LWIDTH-1:0] ram_awlen,
    input  logic              ram_awvalid,
    output logic              ram_awready,
    input  logic [DWIDTH-1:0] ram_wdata,
    output logic              ram_wvalid,
    input  logic              ram_wready,
    output logic              ram_wlast,
    input  logic [AWIDTH-1:0] ram_araddr,
    input  logic [LWIDTH-1:0] ram_arlen,
    input  logic              ram_arvalid,
    output logic              ram_arready,
    output logic [DWIDTH-1:0] ram_rdata,
    output logic              ram_rvalid,
    input  logic              ram_rready,
    output logic              ram_rlast
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [LWIDTH-1:0] cnt_q, cnt_d;
    logic [LWIDTH-1:0] len_q, len_d;
    logic [DWIDTH-1:0] mem [DEPTH];

    logic lastBeat;
    logic awHandshake;
    logic arHandshake;
    logic wBeat;
    logic rBeat;
    logic unusedAddrBits;

    // Byte-offset bits and bits above the array index are dropped, so addresses alias.
    assign unusedAddrBits = ^{ram_awaddr[AWIDTH-1:PW+2], ram_awaddr[1:0],
                              ram_araddr[AWIDTH-1:PW+2], ram_araddr[1:0]};

    assign lastBeat    = (cnt_q == len_q);
    assign awHandshake = ram_awvalid && ram_awready;
    assign arHandshake = ram_arvalid && ram_arready;
    assign wBeat       = ram_wvalid && ram_wready;
    assign rBeat       = ram_rvalid && ram_rready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    // Array is never cleared by reset; wvalid is already gated by rst.
    always_ff @(posedge clk) begin
        if (wBeat) begin
            mem[ptr_q] <= ram_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        case (state_q)
            IDLE: begin
                if (awHandshake) begin
                    ptr_d   = ram_awaddr[PW+1:2];
                    cnt_d   = '0;
                    len_d   = ram_awlen;
                    state_d = WRITE;
                end else if (arHandshake) begin
                    ptr_d   = ram_araddr[PW+1:2];
                    cnt_d   = '0;
                    len_d   = ram_arlen;
                    state_d = READ;
                end
            end
            WRITE: begin
                if (wBeat) begin
                    ptr_d = ptr_q + PW'(1);
                    cnt_d = cnt_q + LWIDTH'(1);
                    if (lastBeat) begin
                        state_d = IDLE;
                    end
                end
            end
            READ: begin
                if (rBeat) begin
                    ptr_d = ptr_q + PW'(1);
                    cnt_d = cnt_q + LWIDTH'(1);
                    if (lastBeat) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Writes win over reads in IDLE so a writeback lands before the refill that follows it.
    always_comb begin
        ram_awready = 1'b0;
        ram_arready = 1'b0;
        ram_wvalid  = 1'b0;
        ram_wlast   = 1'b0;
        ram_rvalid  = 1'b0;
        ram_rlast   = 1'b0;
        ram_rdata   = '0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    ram_awready = 1'b1;
                    ram_arready = !ram_awvalid;
                end
                WRITE: begin
                    ram_wvalid = 1'b1;
                    ram_wlast  = lastBeat;
                end
                READ: begin
                    ram_rvalid = 1'b1;
                    ram_rlast  = lastBeat;
                    ram_rdata  = mem[ptr_q];
                end
                default: ;
            endcase
        end
    end

endmodule
